// File: rtl/lp_pkg.sv
// ---------------------------------------------------------------------------
// lp_pkg : shared types, constants and FP sign helpers for the LP datapath.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lp_pkg;

  localparam int DATA_W = 32;

  localparam logic [31:0] FP_ONE   = 32'h3F80_0000;
  localparam logic [31:0] FP_TWO   = 32'h4000_0000;
  localparam logic [31:0] FP_THREE = 32'h4040_0000;
  localparam logic [31:0] FP_FOUR  = 32'h4080_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } writer_state_t;

  // Strictly negative: -0.0 does not count.
  function automatic logic fp_is_neg(input logic [31:0] v);
    return v[31] && (v[30:0] != 31'd0);
  endfunction

  // Both operands assumed negative and non-NaN: larger magnitude wins.
  function automatic logic fp_more_neg(input logic [31:0] a, input logic [31:0] b);
    return a[30:0] > b[30:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fp_neg_tracker.sv
// ---------------------------------------------------------------------------
// fp_neg_tracker : running most-negative search over objective-row entries.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fp_neg_tracker (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_sample,
  input  logic [31:0] i_data,
  input  logic [15:0] i_col,
  input  logic        i_commit,
  output logic [15:0] o_min_col,
  output logic        o_optimal
);
  import lp_pkg::*;

  logic        r_found;
  logic [30:0] r_best_mag;
  logic [15:0] r_best_col;
  logic        w_take;

  // Strict comparison keeps the lower index on ties.
  assign w_take = i_sample && fp_is_neg(i_data) &&
                  (!r_found || fp_more_neg(i_data, {1'b1, r_best_mag}));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_found    <= 1'b0;
      r_best_mag <= '0;
      r_best_col <= '0;
      o_min_col  <= '0;
      o_optimal  <= 1'b0;
    end else begin
      if (i_clear) begin
        r_found    <= 1'b0;
        r_best_mag <= '0;
        r_best_col <= '0;
      end else if (w_take) begin
        r_found    <= 1'b1;
        r_best_mag <= i_data[30:0];
        r_best_col <= i_col;
      end
      // A clear coinciding with commit is a zero-dimension frame.
      if (i_commit) begin
        o_optimal <= i_clear || !r_found;
        o_min_col <= (i_clear || !r_found) ? 16'd0 : r_best_col;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tableau_result_writer.sv
// ---------------------------------------------------------------------------
// tableau_result_writer : writes a row-major AXI-stream frame into tableau BRAM.
// Optional objective-row pivot search under macro PIVOT_SEARCH_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tableau_result_writer #(
  parameter int          DATA_W    = lp_pkg::DATA_W,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_rows,
  input  logic [15:0]       num_cols,
  input  logic [DATA_W-1:0] s_axis_result_tdata,
  input  logic              s_axis_result_tvalid,
  output logic              s_axis_result_tready,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [DATA_W-1:0] bram_wdata,
  output logic              bram_we,
  output logic              busy,
  output logic              done
`ifdef PIVOT_SEARCH_EN
  ,
  output logic [15:0]       min_col,
  output logic              optimal
`endif
);
  import lp_pkg::*;

  writer_state_t     r_state;
  writer_state_t     w_next;
  logic [15:0]       r_rows;
  logic [15:0]       r_cols;
  logic [15:0]       r_row;
  logic [15:0]       r_col;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_we;
  logic              w_hs;
  logic              w_last_col;
  logic              w_last_row;

  assign s_axis_result_tready = (r_state == RUN);
  assign busy                 = (r_state == RUN);
  assign done                 = (r_state == DONE);
  assign bram_addr            = r_waddr;
  assign bram_wdata           = r_wdata;
  assign bram_we              = r_we;

  assign w_hs       = s_axis_result_tvalid && (r_state == RUN);
  assign w_last_col = (r_col == r_cols - 16'd1);
  assign w_last_row = (r_row == r_rows - 16'd1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = ((num_rows != 16'd0) && (num_cols != 16'd0)) ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_hs && w_last_col && w_last_row) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rows  <= '0;
      r_cols  <= '0;
      r_row   <= '0;
      r_col   <= '0;
      r_addr  <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if ((r_state == IDLE) && start) begin
        r_rows <= num_rows;
        r_cols <= num_cols;
        r_row  <= '0;
        r_col  <= '0;
        r_addr <= ADDR_W'(BASE_ADDR);
      end
      // Address walks linearly; ADDR_W wrap is intentional.
      if (w_hs) begin
        r_we    <= 1'b1;
        r_waddr <= r_addr;
        r_wdata <= s_axis_result_tdata;
        r_addr  <= r_addr + 1'b1;
        if (w_last_col) begin
          r_col <= '0;
          r_row <= r_row + 16'd1;
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

`ifdef PIVOT_SEARCH_EN
  logic w_clear;
  logic w_sample;
  logic w_commit;

  assign w_clear  = (r_state == IDLE) && start;
  assign w_sample = w_hs && (r_row == 16'd0) && !w_last_col;
  assign w_commit = (w_next == DONE) && (r_state != DONE);

  fp_neg_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_sample  (w_sample),
    .i_data    (s_axis_result_tdata[31:0]),
    .i_col     (r_col),
    .i_commit  (w_commit),
    .o_min_col (min_col),
    .o_optimal (optimal)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_tableau_result_writer.sv
// ---------------------------------------------------------------------------
// tb_tableau_result_writer : directed self-checking bench for the result writer.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tableau_result_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] num_rows = '0;
  logic [15:0] num_cols = '0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [15:0] bram_addr;
  logic [31:0] bram_wdata;
  logic        bram_we;
  logic        busy;
  logic        done;
`ifdef PIVOT_SEARCH_EN
  logic [15:0] min_col;
  logic        optimal;
`endif

  tableau_result_writer #(.DATA_W(32), .ADDR_W(16), .BASE_ADDR(0)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .num_rows             (num_rows),
    .num_cols             (num_cols),
    .s_axis_result_tdata  (tdata),
    .s_axis_result_tvalid (tvalid),
    .s_axis_result_tready (tready),
    .bram_addr            (bram_addr),
    .bram_wdata           (bram_wdata),
    .bram_we              (bram_we),
    .busy                 (busy),
    .done                 (done)
`ifdef PIVOT_SEARCH_EN
    ,
    .min_col              (min_col),
    .optimal              (optimal)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // 1.0 .. 12.0 in IEEE754 single
  logic [31:0] fpv [0:11];
  logic [31:0] beat_data [0:15];

  int          cyc = 0;
  int          wcnt, done_cnt, done_wcnt, first_wcyc, last_wcyc;
  logic        tready_seen, done_we, done_busy;
  logic [15:0] wa [0:63];
  logic [31:0] wd [0:63];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bram_we) begin
      if (wcnt < 64) begin
        wa[wcnt] = bram_addr;
        wd[wcnt] = bram_wdata;
      end
      if (wcnt == 0) first_wcyc = cyc;
      last_wcyc = cyc;
      wcnt++;
    end
    if (tready) tready_seen = 1'b1;
    if (done) begin
      done_cnt++;
      done_wcnt = wcnt;
      done_we   = bram_we;
      done_busy = busy;
    end
  end

  task automatic clear_mon();
    wcnt = 0; done_cnt = 0; done_wcnt = -1; first_wcyc = 0; last_wcyc = 0;
    tready_seen = 1'b0; done_we = 1'b0; done_busy = 1'b1;
  endtask

  task automatic do_start(input logic [15:0] r, input logic [15:0] c);
    @(negedge clk);
    start = 1'b1; num_rows = r; num_cols = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input bit gap);
    int  i = 0;
    int  budget = 0;
    bit  hs;
    while (i < n && budget < 200) begin
      tvalid = gap ? (budget % 2 == 0) : 1'b1;
      tdata  = beat_data[i];
      hs     = tvalid && tready;
      @(negedge clk);
      if (hs) i++;
      budget++;
    end
    tvalid = 1'b0;
    if (i != n) chk("beat_timeout", 64'(i), 64'(n));
  endtask

  task automatic wait_done();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) break;
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input bit contiguous);
    chk({tag, "_wcnt"}, 64'(wcnt), 64'd12);
    for (int i = 0; i < 12; i++) begin
      chk({tag, "_addr"}, 64'(wa[i]), 64'(i));
      chk({tag, "_data"}, 64'(wd[i]), 64'(fpv[i]));
    end
    if (contiguous) chk({tag, "_span"}, 64'(last_wcyc - first_wcyc), 64'd11);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, "_done_at_12"}, 64'(done_wcnt), 64'd12);
    chk({tag, "_done_we"}, 64'(done_we), 64'd1);
    chk({tag, "_done_busy"}, 64'(done_busy), 64'd0);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    fpv[0]  = 32'h3F80_0000; fpv[1]  = 32'h4000_0000; fpv[2]  = 32'h4040_0000;
    fpv[3]  = 32'h4080_0000; fpv[4]  = 32'h40A0_0000; fpv[5]  = 32'h40C0_0000;
    fpv[6]  = 32'h40E0_0000; fpv[7]  = 32'h4100_0000; fpv[8]  = 32'h4110_0000;
    fpv[9]  = 32'h4120_0000; fpv[10] = 32'h4130_0000; fpv[11] = 32'h4140_0000;
    for (int i = 0; i < 16; i++) beat_data[i] = (i < 12) ? fpv[i] : 32'h0;
    clear_mon();

    repeat (3) @(negedge clk);
    #1;
    chk("rst_we", 64'(bram_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tready", 64'(tready), 64'd0);
    chk("rst_addr", 64'(bram_addr), 64'd0);
`ifdef PIVOT_SEARCH_EN
    chk("rst_optimal", 64'(optimal), 64'd0);
    chk("rst_min_col", 64'(min_col), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Continuous 3x4 frame
    clear_mon();
    do_start(16'd3, 16'd4);
    send_beats(12, 1'b0);
    wait_done();
    check_frame("cont", 1'b1);

    // Same frame with toggling tvalid
    clear_mon();
    do_start(16'd3, 16'd4);
    send_beats(12, 1'b1);
    wait_done();
    check_frame("gap", 1'b0);

    // Zero-dimension frame
    clear_mon();
    do_start(16'd0, 16'd4);
    #1;
    chk("zero_done_next", 64'(done), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_writes", 64'(wcnt), 64'd0);
    chk("zero_done_cnt", 64'(done_cnt), 64'd1);
    chk("zero_tready", 64'(tready_seen), 64'd0);
`ifdef PIVOT_SEARCH_EN
    chk("zero_optimal", 64'(optimal), 64'd1);
    chk("zero_min_col", 64'(min_col), 64'd0);
`endif

    // Reset mid-frame after 5 handshakes
    clear_mon();
    do_start(16'd3, 16'd4);
    send_beats(5, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_we", 64'(bram_we), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    tvalid = 1'b1;
    repeat (6) @(negedge clk);
    tvalid = 1'b0;
    #1;
    chk("midrst_writes", 64'(wcnt), 64'd5);
    chk("midrst_done", 64'(done_cnt), 64'd0);
    chk("midrst_busy_after", 64'(busy), 64'd0);
    clear_mon();
    do_start(16'd3, 16'd4);
    send_beats(12, 1'b0);
    wait_done();
    check_frame("restart", 1'b1);

`ifdef PIVOT_SEARCH_EN
    // Objective row {-1,-3,-3,-5}: RHS ignored, tie keeps col 1
    beat_data[0] = 32'hBF80_0000; beat_data[1] = 32'hC040_0000;
    beat_data[2] = 32'hC040_0000; beat_data[3] = 32'hC0A0_0000;
    beat_data[4] = fpv[0]; beat_data[5] = fpv[1]; beat_data[6] = fpv[2]; beat_data[7] = fpv[3];
    clear_mon();
    do_start(16'd2, 16'd4);
    send_beats(8, 1'b0);
    wait_done();
    chk("piv1_min_col", 64'(min_col), 64'd1);
    chk("piv1_optimal", 64'(optimal), 64'd0);
    chk("piv1_writes", 64'(wcnt), 64'd8);

    // Objective row {2,-0,1,4}: no negative entry
    beat_data[0] = 32'h4000_0000; beat_data[1] = 32'h8000_0000;
    beat_data[2] = 32'h3F80_0000; beat_data[3] = 32'h4080_0000;
    clear_mon();
    do_start(16'd2, 16'd4);
    send_beats(8, 1'b1);
    wait_done();
    chk("piv2_min_col", 64'(min_col), 64'd0);
    chk("piv2_optimal", 64'(optimal), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
